// File: rtl/multi_edge_pkg.sv
// rtl/multi_edge_pkg.sv - shared encodings for the multi-channel edge detector
package multi_edge_pkg;

    localparam logic [1:0] MODE_OFF  = 2'b00;
    localparam logic [1:0] MODE_RISE = 2'b01;
    localparam logic [1:0] MODE_FALL = 2'b10;
    localparam logic [1:0] MODE_BOTH = 2'b11;

    typedef enum logic [2:0] {
        ST_INIT   = 3'd0,
        ST_LOW    = 3'd1,
        ST_HIGH   = 3'd2,
        ST_PEND_H = 3'd3,
        ST_PEND_L = 3'd4
    } state_t;

endpackage

// File: rtl/edge_chan.sv
// rtl/edge_chan.sv - one channel: stability filter FSM, edge qualification, saturating event counter
module edge_chan
    import multi_edge_pkg::*;
#(
    parameter int STABLE_CNT = 3,
    parameter int CNT_W      = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             din,
    input  logic [1:0]       mode,
    input  logic             clr,
    output logic             pulse,
    output logic             pulse_next,
    output logic             level,
    output logic [CNT_W-1:0] count
);

    localparam int              SC_W      = (STABLE_CNT > 1) ? $clog2(STABLE_CNT) : 1;
    localparam bit              IMMEDIATE = (STABLE_CNT <= 1);
    localparam logic [SC_W-1:0] SC_LAST   = SC_W'(STABLE_CNT - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    state_t          state;
    logic [SC_W-1:0] scnt;
    logic            accept_rise;
    logic            accept_fall;
    logic            rise_en;
    logic            fall_en;

    // scnt holds how many new-value samples were already seen; this sample completes the run
    always_comb begin
        accept_rise = din  && ((state == ST_LOW  && IMMEDIATE) || (state == ST_PEND_H && scnt == SC_LAST));
        accept_fall = !din && ((state == ST_HIGH && IMMEDIATE) || (state == ST_PEND_L && scnt == SC_LAST));
        rise_en     = (mode == MODE_RISE) || (mode == MODE_BOTH);
        fall_en     = (mode == MODE_FALL) || (mode == MODE_BOTH);
        pulse_next  = (accept_rise && rise_en) || (accept_fall && fall_en);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_INIT;
            scnt  <= '0;
            level <= 1'b0;
            pulse <= 1'b0;
            count <= '0;
        end else begin
            pulse <= pulse_next;

            if (clr) begin
                count <= '0;
            end else if (pulse_next && count != CNT_MAX) begin
                count <= count + 1'b1;
            end

            case (state)
                ST_INIT: begin
                    state <= din ? ST_HIGH : ST_LOW;
                    level <= din;
                    scnt  <= '0;
                end
                ST_LOW: begin
                    if (din) begin
                        if (IMMEDIATE) begin
                            state <= ST_HIGH;
                            level <= 1'b1;
                        end else begin
                            state <= ST_PEND_H;
                            scnt  <= SC_W'(1);
                        end
                    end
                end
                ST_PEND_H: begin
                    if (!din) begin
                        state <= ST_LOW;
                        scnt  <= '0;
                    end else if (accept_rise) begin
                        state <= ST_HIGH;
                        level <= 1'b1;
                        scnt  <= '0;
                    end else begin
                        scnt <= scnt + 1'b1;
                    end
                end
                ST_HIGH: begin
                    if (!din) begin
                        if (IMMEDIATE) begin
                            state <= ST_LOW;
                            level <= 1'b0;
                        end else begin
                            state <= ST_PEND_L;
                            scnt  <= SC_W'(1);
                        end
                    end
                end
                ST_PEND_L: begin
                    if (din) begin
                        state <= ST_HIGH;
                        scnt  <= '0;
                    end else if (accept_fall) begin
                        state <= ST_LOW;
                        level <= 1'b0;
                        scnt  <= '0;
                    end else begin
                        scnt <= scnt + 1'b1;
                    end
                end
                default: begin
                    state <= ST_INIT;
                    scnt  <= '0;
                end
            endcase
        end
    end

endmodule

// File: rtl/multi_edge_detector.sv
// rtl/multi_edge_detector.sv - N_CH filtered edge detectors with per-channel mode and event counters
module multi_edge_detector
    import multi_edge_pkg::*;
#(
    parameter int N_CH       = 4,
    parameter int STABLE_CNT = 3,
    parameter int CNT_W      = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [N_CH-1:0]       din,
    input  logic [2*N_CH-1:0]     mode,
    input  logic                  clr,
    output logic [N_CH-1:0]       edge_o,
    output logic [N_CH-1:0]       level_o,
    output logic                  any_o,
    output logic [N_CH*CNT_W-1:0] cnt_o
);

    logic [N_CH-1:0] pulse_next;

    for (genvar gi = 0; gi < N_CH; gi++) begin : g_chan
        edge_chan #(
            .STABLE_CNT (STABLE_CNT),
            .CNT_W      (CNT_W)
        ) u_chan (
            .clk        (clk),
            .rst_n      (rst_n),
            .din        (din[gi]),
            .mode       (mode[2*gi +: 2]),
            .clr        (clr),
            .pulse      (edge_o[gi]),
            .pulse_next (pulse_next[gi]),
            .level      (level_o[gi]),
            .count      (cnt_o[gi*CNT_W +: CNT_W])
        );
    end

    // OR the pre-register pulses so any_o lands in the same cycle as edge_o
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            any_o <= 1'b0;
        end else begin
            any_o <= |pulse_next;
        end
    end

endmodule

// File: doc/multi_edge_detector.md
Name: multi_edge_detector

Overview:
- Parametrised, multi-channel successor to the single-bit Mealy change detector.
- Each channel filters a synchronous input bit for stability, then tracks its level with a small FSM.
- On accepted edges that match the channel's mode (rise/fall/both/off), it emits a registered one-cycle pulse and bumps a saturating per-channel event counter.
- Sits between synchronised status/button inputs and control logic that needs clean edge events.

Parameters:
- N_CH, 4, number of independent channels.
- STABLE_CNT, 3, consecutive identical samples (>=1) required before a level change is accepted; 1 = accept immediately.
- CNT_W, 8, width of each per-channel event counter.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- din  in  N_CH  raw channel inputs, already synchronous to clk.
- mode  in  2*N_CH  per-channel mode, channel k at [2k+1:2k]. Encoding: 00 off, 01 rise, 10 fall, 11 both.
- clr  in  1  synchronous clear of all event counters.
- edge_o  out  N_CH  registered one-cycle pulse per qualifying accepted edge.
- level_o  out  N_CH  filtered (accepted) level per channel.
- any_o  out  1  registered OR of all edge_o bits (same cycle as edge_o).
- cnt_o  out  N_CH*CNT_W  per-channel event counts, channel k at [(k+1)*CNT_W-1:k*CNT_W].

Behaviour:
- Reset (rst_n=0, async): all channels go to INIT. edge_o=0, level_o=0, any_o=0, cnt_o=0, stability counters=0.
- Per-channel FSM has states INIT, LOW, HIGH, PEND_H, PEND_L.
- INIT, first clock after reset release: go to LOW if din=0, HIGH if din=1. level_o follows. No pulse and no count; the initial level is never an edge.
- LOW:
  - din=0: stay.
  - din=1 and STABLE_CNT=1: go to HIGH and accept a rising edge.
  - din=1 and STABLE_CNT>1: go to PEND_H, scnt=1.
- PEND_H:
  - din=0: return to LOW, scnt=0 (glitch rejected, no pulse).
  - din=1: scnt++; when scnt reaches STABLE_CNT, go to HIGH and accept a rising edge.
- HIGH / PEND_L: mirror of LOW / PEND_H for falling edges.
- Latency: an edge is accepted at the clock edge sampling the STABLE_CNT-th consecutive new value. At that same edge, edge_o, level_o and any_o update, so they are visible for the following cycle. edge_o is high for exactly one cycle.
- Qualification:
  - Rising edge pulses iff mode bit0=1; falling edge pulses iff mode bit1=1.
  - mode=00 suppresses pulses and counts, but the FSM and level_o keep tracking.
  - mode is sampled at the acceptance edge; changing mode never creates or cancels a pending filter.
- Counter:
  - Increments by 1 on each qualifying pulse.
  - Saturates at 2^CNT_W-1 and never wraps.
  - clr=1 forces all counters to 0 at that edge. If clr and a qualifying event coincide, clear wins (result 0); the edge_o pulse still fires.
- Back-to-back: a new edge can be accepted STABLE_CNT cycles after the previous one. Consecutive pulses on one channel are separated by at least STABLE_CNT-1 low cycles when STABLE_CNT>1, and can be every cycle when STABLE_CNT=1 with toggling din.
- Channels are fully independent; simultaneous edges on several channels pulse in the same cycle.
- Reset asserted mid-filter or mid-pulse: immediate return to the reset values above. The next accepted level after release again comes through INIT (no pulse).

Decomposition:
- Package multi_edge_pkg holds:
  - mode encodings MODE_OFF/MODE_RISE/MODE_FALL/MODE_BOTH;
  - FSM state encodings ST_INIT/ST_LOW/ST_HIGH/ST_PEND_H/ST_PEND_L.
- One sub-module, edge_chan: one channel's FSM, stability counter, qualification and saturating counter. It is instantiated N_CH times via generate.
- The top level does the port slicing and the any_o OR/register.

Test Plan:
- Release reset with din=4'b0101, then hold steady for 10 cycles -> level_o=0101, edge_o never asserts, cnt_o all 0.
- Ch0 mode=01, STABLE_CNT=3: din[0] goes 0->1 and is held 3 samples -> edge_o[0]=1 for one cycle after the 3rd sample, level_o[0]=1, cnt0=1, any_o pulses with it.
- Ch1 mode=11: 2-cycle high glitch on din[1] (STABLE_CNT=3) -> no pulse, level_o[1] stays 0. Then a 3-cycle high followed by a 3-cycle low -> two pulses, cnt1=2.
- Ch2 mode=10, CNT_W=2: five accepted falling edges -> cnt2 reaches 3 and holds. Assert clr coincident with a 6th fall -> edge_o[2] pulses, cnt2=0.
- Ch3 mode=00 with toggling din -> level_o[3] tracks, edge_o[3]=0, cnt3=0. Switch to mode=01 mid-PEND_H -> the pending rise pulses on acceptance.
- Drop rst_n during PEND_H on ch0 -> all outputs immediately 0. After release with din[0]=1 -> level_o[0]=1 via INIT, no pulse.
